// File: rtl/int_div_unit_if.sv
// Handshake and data bundle between the execute stage and the iterative divider.
// The master side issues operations; the slave side (the divider) returns results.
interface int_div_unit_if #(
  parameter int XLEN = 32
);
  logic            IDiv;
  logic [1:0]      div_op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            div_busy;
  logic            Div_Done;
  logic [XLEN-1:0] div_result;
  logic [4:0]      div_rd;

  modport master (
    output IDiv, div_op, rs1_data, rs2_data, rd_in,
    input  div_busy, Div_Done, div_result, div_rd
  );

  modport slave (
    input  IDiv, div_op, rs1_data, rs2_data, rd_in,
    output div_busy, Div_Done, div_result, div_rd
  );
endinterface

// File: rtl/int_div_unit.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module int_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic          CLK,
  input  logic          rst,
  int_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0]  ZERO_W    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES_W    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(XLEN);

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             busy_r;
  logic             done_r;
  logic             busy_nxt_s;
  logic             done_nxt_s;

  logic [1:0]       op_r;
  logic [4:0]       rd_r;
  logic [XLEN-1:0]  result_r;
  logic [XLEN-1:0]  quot_r;
  logic [XLEN-1:0]  rem_r;
  logic [XLEN-1:0]  divisor_r;
  logic [CNT_W-1:0] cnt_r;
  logic             qsign_r;
  logic             rsign_r;

  logic             is_signed_s;
  logic             is_rem_s;
  logic             div_zero_s;
  logic             overflow_s;
  logic             fast_s;
  logic [XLEN-1:0]  fast_result_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [XLEN-1:0]  a_abs_s;
  logic [XLEN-1:0]  b_abs_s;
  logic [XLEN:0]    rem_shift_s;
  logic [XLEN:0]    diff_s;
  logic [XLEN-1:0]  rem_step_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [XLEN-1:0]  quot_fix_s;
  logic [XLEN-1:0]  rem_fix_s;

  // div_op[0] = 0 selects the signed variants, div_op[1] = 1 selects the remainder
  assign is_signed_s = ~bus.div_op[0];
  assign is_rem_s    = bus.div_op[1];
  assign div_zero_s  = (bus.rs2_data == ZERO_W);
  assign overflow_s  = is_signed_s && (bus.rs1_data == MIN_NEG) && (bus.rs2_data == ONES_W);
  assign fast_s      = div_zero_s || overflow_s;
  assign a_neg_s     = is_signed_s && bus.rs1_data[XLEN-1];
  assign b_neg_s     = is_signed_s && bus.rs2_data[XLEN-1];
  assign a_abs_s     = a_neg_s ? twos_neg(bus.rs1_data) : bus.rs1_data;
  assign b_abs_s     = b_neg_s ? twos_neg(bus.rs2_data) : bus.rs2_data;

  // The shifted remainder can reach 2*divisor-1, so the trial subtract needs one extra bit.
  assign rem_shift_s = {rem_r, quot_r[XLEN-1]};
  assign diff_s      = rem_shift_s - {1'b0, divisor_r};
  assign rem_step_s  = diff_s[XLEN] ? rem_shift_s[XLEN-1:0] : diff_s[XLEN-1:0];
  assign cnt_inc_s   = cnt_r + CNT_ONE;
  assign quot_fix_s  = qsign_r ? twos_neg(quot_r) : quot_r;
  assign rem_fix_s   = rsign_r ? twos_neg(rem_r) : rem_r;

  // Fast-path result for divide-by-zero and signed overflow.
  always_comb begin
    fast_result_s = ZERO_W;
    if (div_zero_s) begin
      fast_result_s = is_rem_s ? bus.rs1_data : ONES_W;
    end else begin
      fast_result_s = is_rem_s ? ZERO_W : MIN_NEG;
    end
  end

  // State register plus registered status outputs.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.IDiv) begin
          state_nxt_s = fast_s ? S_DONE : S_CALC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_inc_s == CNT_LAST) begin
          state_nxt_s = S_SIGN;
        end else begin
          state_nxt_s = S_CALC;
        end
      end
      S_SIGN:  state_nxt_s = S_DONE;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they are registered with it.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      S_IDLE:  begin busy_nxt_s = 1'b0; done_nxt_s = 1'b0; end
      S_CALC:  begin busy_nxt_s = 1'b1; done_nxt_s = 1'b0; end
      S_SIGN:  begin busy_nxt_s = 1'b1; done_nxt_s = 1'b0; end
      S_DONE:  begin busy_nxt_s = 1'b1; done_nxt_s = 1'b1; end
      default: begin busy_nxt_s = 1'b0; done_nxt_s = 1'b0; end
    endcase
  end

  // Operand capture, radix-2 iteration and sign fix-up.
  always_ff @(posedge CLK) begin
    if (rst) begin
      op_r      <= 2'b00;
      rd_r      <= 5'd0;
      result_r  <= ZERO_W;
      quot_r    <= ZERO_W;
      rem_r     <= ZERO_W;
      divisor_r <= ZERO_W;
      cnt_r     <= CNT_ZERO;
      qsign_r   <= 1'b0;
      rsign_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.IDiv) begin
            op_r      <= bus.div_op;
            rd_r      <= bus.rd_in;
            cnt_r     <= CNT_ZERO;
            rem_r     <= ZERO_W;
            quot_r    <= a_abs_s;
            divisor_r <= b_abs_s;
            qsign_r   <= a_neg_s ^ b_neg_s;
            rsign_r   <= a_neg_s;
            if (fast_s) begin
              result_r <= fast_result_s;
            end
          end
        end
        S_CALC: begin
          rem_r  <= rem_step_s;
          quot_r <= {quot_r[XLEN-2:0], ~diff_s[XLEN]};
          cnt_r  <= cnt_inc_s;
        end
        S_SIGN: begin
          result_r <= op_r[1] ? rem_fix_s : quot_fix_s;
        end
        S_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  assign bus.div_busy   = busy_r;
  assign bus.Div_Done   = done_r;
  assign bus.div_result = result_r;
  assign bus.div_rd     = rd_r;

endmodule

// File: tb/tb_int_div_unit.sv
// Self-checking bench for int_div_unit: directed RV32M cases, busy/reset handling,
// and random operations compared against an arithmetic reference model.
module tb_int_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  int_div_unit_if #(.XLEN(32)) bif ();

  int_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bif)
  );

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // RISC-V M-extension semantics using plain 64-bit arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0] == 1'b0) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 0;
    if (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation, waits (bounded) for Div_Done and checks result, tag and latency.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    int lat;
    @(negedge clk);
    bif.IDiv = 1'b1; bif.div_op = op; bif.rs1_data = a; bif.rs2_data = b; bif.rd_in = rd;
    @(negedge clk);
    bif.IDiv = 1'b0;
    bif.rs1_data = $urandom; bif.rs2_data = $urandom; bif.rd_in = 5'($urandom);
    bif.div_op = 2'($urandom);
    check({tag, ".busy"}, {31'd0, bif.div_busy}, 32'd1);
    lat = 0;
    while (bif.Div_Done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, ref_lat(op, a, b));
    check({tag, ".result"}, bif.div_result, ref_div(op, a, b));
    check({tag, ".rd"}, {27'd0, bif.div_rd}, {27'd0, rd});
    @(negedge clk);
    check({tag, ".done_drop"}, {31'd0, bif.Div_Done}, 32'd0);
  endtask

  initial begin
    int pulses, lat;
    logic [31:0] res;
    logic [4:0]  rdv;
    logic [1:0]  op;
    logic [31:0] a, b;
    int sel;

    rst = 1'b1;
    bif.IDiv = 1'b0; bif.div_op = 2'b00; bif.rs1_data = 32'd0; bif.rs2_data = 32'd0;
    bif.rd_in = 5'd0;
    repeat (3) @(negedge clk);
    check("reset.busy", {31'd0, bif.div_busy}, 32'd0);
    check("reset.done", {31'd0, bif.Div_Done}, 32'd0);
    check("reset.result", bif.div_result, 32'd0);
    check("reset.rd", {27'd0, bif.div_rd}, 32'd0);
    rst = 1'b0;

    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd1);
    check("divu_100_7.value", bif.div_result, 32'd14);
    do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd2);
    check("remu_100_7.value", bif.div_result, 32'd2);
    do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3);
    check("div_m7_2.value", bif.div_result, 32'hFFFF_FFFD);
    do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4);
    check("rem_m7_2.value", bif.div_result, 32'hFFFF_FFFF);
    do_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd5);
    check("div_7_m2.value", bif.div_result, 32'hFFFF_FFFD);
    do_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd6);
    check("rem_7_m2.value", bif.div_result, 32'd1);
    do_op("div_5_0", OP_DIV, 32'd5, 32'd0, 5'd7);
    check("div_5_0.value", bif.div_result, 32'hFFFF_FFFF);
    do_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 5'd8);
    check("remu_5_0.value", bif.div_result, 32'd5);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    check("div_ovf.value", bif.div_result, 32'h8000_0000);
    do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    check("rem_ovf.value", bif.div_result, 32'd0);
    do_op("divu_ovf_pattern", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    do_op("div_zero_dividend", OP_DIV, 32'd0, 32'd13, 5'd12);
    check("div_zero_dividend.value", bif.div_result, 32'd0);

    // IDiv toggled with fresh operands during CALC must not disturb the operation.
    @(negedge clk);
    bif.IDiv = 1'b1; bif.div_op = OP_DIVU; bif.rs1_data = 32'd1000; bif.rs2_data = 32'd10;
    bif.rd_in = 5'd7;
    @(negedge clk);
    pulses = 0; lat = -1; res = 32'd0; rdv = 5'd0;
    for (int i = 0; i < 45; i++) begin
      if (i > 0) @(negedge clk);
      if (bif.Div_Done === 1'b1) begin
        pulses++;
        if (lat < 0) begin lat = i; res = bif.div_result; rdv = bif.div_rd; end
      end
      bif.IDiv = (i < 32) ? 1'(i % 2) : 1'b0;
      bif.div_op = 2'($urandom); bif.rs1_data = $urandom; bif.rs2_data = $urandom;
      bif.rd_in = 5'($urandom);
    end
    bif.IDiv = 1'b0;
    check("busy_toggle.pulses", pulses, 32'd1);
    check("busy_toggle.latency", lat, 32'd33);
    check("busy_toggle.result", res, 32'd100);
    check("busy_toggle.rd", {27'd0, rdv}, 32'd7);

    // IDiv held through DONE is accepted only in the following IDLE cycle.
    @(negedge clk);
    bif.IDiv = 1'b1; bif.div_op = OP_DIV; bif.rs1_data = 32'd5; bif.rs2_data = 32'd0;
    bif.rd_in = 5'd3;
    @(negedge clk);
    check("done_hold.done", {31'd0, bif.Div_Done}, 32'd1);
    bif.div_op = OP_DIVU; bif.rs1_data = 32'd9; bif.rs2_data = 32'd3; bif.rd_in = 5'd4;
    @(negedge clk);
    check("done_hold.idle_busy", {31'd0, bif.div_busy}, 32'd0);
    check("done_hold.idle_done", {31'd0, bif.Div_Done}, 32'd0);
    check("done_hold.first_result", bif.div_result, 32'hFFFF_FFFF);
    @(negedge clk);
    bif.IDiv = 1'b0;
    check("done_hold.accepted", {31'd0, bif.div_busy}, 32'd1);
    lat = 0;
    while (bif.Div_Done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("done_hold.latency", lat, 32'd33);
    check("done_hold.result", bif.div_result, 32'd3);
    check("done_hold.rd", {27'd0, bif.div_rd}, 32'd4);

    // Reset at edge T+10 of an in-flight DIVU drops it.
    @(negedge clk);
    bif.IDiv = 1'b1; bif.div_op = OP_DIVU; bif.rs1_data = 32'd1000; bif.rs2_data = 32'd3;
    bif.rd_in = 5'd9;
    @(negedge clk);
    bif.IDiv = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset.busy", {31'd0, bif.div_busy}, 32'd0);
    check("midreset.done", {31'd0, bif.Div_Done}, 32'd0);
    check("midreset.result", bif.div_result, 32'd0);
    check("midreset.rd", {27'd0, bif.div_rd}, 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bif.Div_Done === 1'b1) pulses++;
    end
    check("midreset.no_done", pulses, 32'd0);
    do_op("after_reset_9_3", OP_DIVU, 32'd9, 32'd3, 5'd14);
    check("after_reset_9_3.value", bif.div_result, 32'd3);

    // Random operations, with operands biased toward the special cases.
    for (int n = 0; n < 1000; n++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 255);
        3: a = $urandom_range(0, 255);
        4: b = {24'hFFFFFF, 8'($urandom)};
        default: ;
      endcase
      do_op("random", op, a, b, 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
